// File: rtl/pc_fetch_unit.sv
// Program counter plus req/ack instruction fetch with a one-entry skid buffer and jump squash.
// Optional macro PC_DELAY_SLOT_EN keeps the oldest live word across a taken jump.
module pc_fetch_unit #(
    parameter int                  PC_WIDTH   = 16,
    parameter int                  INST_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 16'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_en,
    input  logic [PC_WIDTH-1:0]   jump_target,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    output logic [PC_WIDTH-1:0]   if_pc,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic [PC_WIDTH-1:0]   pc
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BLOCK = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic                  drop_r;
    logic                  skid_valid_r;
    logic [PC_WIDTH-1:0]   skid_pc_r;
    logic [INST_WIDTH-1:0] skid_inst_r;
    logic                  out_free_s;
    logic                  drain_s;
    logic [PC_WIDTH-1:0]   fetch_next_s;

    assign out_free_s = !if_valid || !stall;
    assign drain_s    = if_valid && !stall;

`ifdef PC_DELAY_SLOT_EN
    // A word kept across a jump was fetched before the redirect, so its ack must not bump pc.
    logic keep_r;
    assign fetch_next_s = keep_r ? pc : (pc + PC_ONE);
`else
    assign fetch_next_s = pc + PC_ONE;
`endif

    // Fetch state machine, pc, skid buffer and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            imem_addr    <= {PC_WIDTH{1'b0}};
            if_valid     <= 1'b0;
            if_pc        <= {PC_WIDTH{1'b0}};
            if_inst      <= {INST_WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            skid_pc_r    <= {PC_WIDTH{1'b0}};
            skid_inst_r  <= {INST_WIDTH{1'b0}};
            drop_r       <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
            keep_r       <= 1'b0;
`endif
        end else begin
            if (drain_s) begin
                if_valid <= 1'b0;
            end
            if (jump_en) begin
                pc           <= jump_target;
                if_valid     <= 1'b0;
                skid_valid_r <= 1'b0;
                case (state_r)
                    REQ: begin
                        if (imem_ack) begin
                            imem_addr <= jump_target;
                            drop_r    <= 1'b0;
                        end else begin
                            drop_r    <= 1'b1;
                        end
                    end
                    default: begin
                        state_r   <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= jump_target;
                    end
                endcase
`ifdef PC_DELAY_SLOT_EN
                keep_r <= 1'b0;
                if (if_valid && stall) begin
                    if_valid <= 1'b1;
                end else if (skid_valid_r) begin
                    if_valid <= 1'b1;
                    if_pc    <= skid_pc_r;
                    if_inst  <= skid_inst_r;
                end else if ((state_r == REQ) && !drop_r) begin
                    if (imem_ack) begin
                        if_valid <= 1'b1;
                        if_pc    <= imem_addr;
                        if_inst  <= imem_rdata;
                    end else begin
                        drop_r <= 1'b0;
                        keep_r <= 1'b1;
                    end
                end
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r   <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                    REQ: begin
                        if (imem_ack && drop_r) begin
                            drop_r    <= 1'b0;
                            imem_addr <= pc;
                        end else if (imem_ack) begin
`ifdef PC_DELAY_SLOT_EN
                            keep_r <= 1'b0;
`endif
                            pc <= fetch_next_s;
                            if (out_free_s) begin
                                if_valid  <= 1'b1;
                                if_pc     <= imem_addr;
                                if_inst   <= imem_rdata;
                                imem_addr <= fetch_next_s;
                            end else begin
                                skid_valid_r <= 1'b1;
                                skid_pc_r    <= imem_addr;
                                skid_inst_r  <= imem_rdata;
                                state_r      <= BLOCK;
                                imem_req     <= 1'b0;
                            end
                        end
                    end
                    BLOCK: begin
                        if (drain_s) begin
                            if_valid     <= 1'b1;
                            if_pc        <= skid_pc_r;
                            if_inst      <= skid_inst_r;
                            skid_valid_r <= 1'b0;
                            state_r      <= REQ;
                            imem_req     <= 1'b1;
                            imem_addr    <= pc;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        imem_req <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
